// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register selects, stall FSM encoding and the latch-control
// bundle driven by the stall controller.
package cpu_types_pkg;

    localparam int unsigned REGBITS_W   = 5;
    localparam int unsigned STALL_CNT_W = 16;

    typedef logic [REGBITS_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DWAIT  = 2'b01,
        HALTED = 2'b10
    } stallstate_t;

    // Enables for PC and the four pipeline latches, plus clear-to-NOP strobes
    typedef struct packed {
        logic pc_en;
        logic en_ifid;
        logic en_idex;
        logic en_exmem;
        logic en_memwb;
        logic flush_ifid;
        logic flush_idex;
    } stall_ctl_t;

    localparam stall_ctl_t CTL_NONE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam stall_ctl_t CTL_ALL    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam stall_ctl_t CTL_HALT   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam stall_ctl_t CTL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam stall_ctl_t CTL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Load in ID/EX whose destination is read by the instruction in IF/ID
    function automatic logic load_use_hit(input logic     is_load,
                                          input regbits_t wsel,
                                          input regbits_t rs,
                                          input regbits_t rt);
        return is_load && (wsel != '0) && ((wsel == rs) || (wsel == rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: resolves load-use, cache wait, taken branch
// and halt hazards by gating PC and latch enables; counts stalled cycles.
module pipe_stall_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = STALL_CNT_W,
    parameter int unsigned REG_W = REGBITS_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [31:0]      instr_out_1,
    input  logic             dREN_out_2,
    input  logic [REG_W-1:0] wsel_out_2,
    input  logic             dREN_out_3,
    input  logic             dWEN_out_3,
    input  logic             pcsrc_taken_2,
    input  logic             halt_out_4,
    output logic             pc_en,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state_o
);

    stallstate_t state, state_nxt;
    logic        flush_pend, flush_pend_nxt;
    stall_ctl_t  ctl;
    logic        dmem_busy;
    logic        load_use;
    regbits_t    rs, rt;
    logic        unused_instr_bits;

    assign rs = instr_out_1[25:21];
    assign rt = instr_out_1[20:16];
    assign unused_instr_bits = ^{instr_out_1[31:26], instr_out_1[15:0]};

    assign dmem_busy = (dREN_out_3 || dWEN_out_3) && !dhit;
    assign load_use  = load_use_hit(dREN_out_2, REGBITS_W'(wsel_out_2), rs, rt);

    // State register plus the deferred-flush flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    // Next-state logic; a branch seen while memory is busy is parked in flush_pend
    always_comb begin
        state_nxt      = state;
        flush_pend_nxt = flush_pend;
        case (state)
            HALTED: begin
                state_nxt = HALTED;
            end
            RUN, DWAIT: begin
                if (halt_out_4) begin
                    state_nxt      = HALTED;
                    flush_pend_nxt = 1'b0;
                end else if (dmem_busy) begin
                    state_nxt = DWAIT;
                    if (pcsrc_taken_2) begin
                        flush_pend_nxt = 1'b1;
                    end
                end else if (state == DWAIT) begin
                    state_nxt = RUN;
                end else if (pcsrc_taken_2 || flush_pend) begin
                    flush_pend_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt      = RUN;
                flush_pend_nxt = 1'b0;
            end
        endcase
    end

    // Output decode, same priority order as the next-state logic
    always_comb begin
        ctl = CTL_NONE;
        if (RST) begin
            ctl = CTL_NONE;
        end else begin
            case (state)
                RUN, DWAIT: begin
                    if (halt_out_4) begin
                        ctl = CTL_HALT;
                    end else if (dmem_busy) begin
                        ctl = CTL_NONE;
                    end else if (state == DWAIT) begin
                        ctl = CTL_ALL;
                    end else if (pcsrc_taken_2 || flush_pend) begin
                        ctl = CTL_BRANCH;
                    end else if (load_use || !ihit) begin
                        ctl = CTL_BUBBLE;
                    end else begin
                        ctl = CTL_ALL;
                    end
                end
                default: begin
                    ctl = CTL_NONE;
                end
            endcase
        end
    end

    assign pc_en      = ctl.pc_en;
    assign en_ifid    = ctl.en_ifid;
    assign en_idex    = ctl.en_idex;
    assign en_exmem   = ctl.en_exmem;
    assign en_memwb   = ctl.en_memwb;
    assign flush_ifid = ctl.flush_ifid;
    assign flush_idex = ctl.flush_idex;
    assign halt       = (state == HALTED);
    assign state_o    = state;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (CLK),
        .clr (RST),
        .inc (!ctl.pc_en && (state != HALTED)),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed-vector bench for pipe_stall_ctrl: table of cycle vectors plus
// hand-written halt and counter-saturation sequences.
module tb_pipe_stall_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit;
    logic [31:0] instr_out_1;
    logic        dREN_out_2;
    logic [4:0]  wsel_out_2;
    logic        dREN_out_3, dWEN_out_3, pcsrc_taken_2, halt_out_4;
    logic        pc_en, en_ifid, en_idex, en_exmem, en_memwb;
    logic        flush_ifid, flush_idex, halt;
    logic [15:0] stall_cnt;
    logic [1:0]  state_o;

    always #5 CLK = ~CLK;

    pipe_stall_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .ihit          (ihit),
        .dhit          (dhit),
        .instr_out_1   (instr_out_1),
        .dREN_out_2    (dREN_out_2),
        .wsel_out_2    (wsel_out_2),
        .dREN_out_3    (dREN_out_3),
        .dWEN_out_3    (dWEN_out_3),
        .pcsrc_taken_2 (pcsrc_taken_2),
        .halt_out_4    (halt_out_4),
        .pc_en         (pc_en),
        .en_ifid       (en_ifid),
        .en_idex       (en_idex),
        .en_exmem      (en_exmem),
        .en_memwb      (en_memwb),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .halt          (halt),
        .stall_cnt     (stall_cnt),
        .state_o       (state_o)
    );

    // ctl order: pc_en en_ifid en_idex en_exmem en_memwb flush_ifid flush_idex
    localparam logic [6:0] C_N  = 7'b0000000;
    localparam logic [6:0] C_A  = 7'b1111100;
    localparam logic [6:0] C_LU = 7'b0011101;
    localparam logic [6:0] C_BR = 7'b1111111;
    localparam logic [6:0] C_H  = 7'b0000100;

    typedef struct {
        logic        rst, ihit, dhit;
        logic [31:0] instr;
        logic        dren2;
        logic [4:0]  wsel;
        logic        dren3, dwen3, pcsrc, halt4;
        logic [6:0]  ctl;
        logic        hlt;
        logic [1:0]  st;
        logic [15:0] cnt;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic ih, logic dh, logic [4:0] rs, logic [4:0] rt,
                                logic dr2, logic [4:0] ws, logic dr3, logic dw3, logic pc,
                                logic h4, logic [6:0] ctl, logic hl, logic [1:0] st,
                                logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.ihit = ih; v.dhit = dh;
        v.instr = {6'h23, rs, rt, 16'h0040};
        v.dren2 = dr2; v.wsel = ws; v.dren3 = dr3; v.dwen3 = dw3;
        v.pcsrc = pc; v.halt4 = h4;
        v.ctl = ctl; v.hlt = hl; v.st = st; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        RST = v.rst; ihit = v.ihit; dhit = v.dhit; instr_out_1 = v.instr;
        dREN_out_2 = v.dren2; wsel_out_2 = v.wsel; dREN_out_3 = v.dren3;
        dWEN_out_3 = v.dwen3; pcsrc_taken_2 = v.pcsrc; halt_out_4 = v.halt4;
    endtask

    task automatic check(input string name, input logic [6:0] ctl, input logic hl,
                         input logic [1:0] st, input logic [15:0] cnt);
        logic [6:0] got;
        got = {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex};
        n_vec++;
        if (got !== ctl || halt !== hl || state_o !== st || stall_cnt !== cnt) begin
            n_err++;
            $display("FAIL %s: got ctl=%b halt=%b state=%b cnt=%0d, expected ctl=%b halt=%b state=%b cnt=%0d",
                     name, got, halt, state_o, stall_cnt, ctl, hl, st, cnt);
        end
    endtask

    // One cycle: drive at negedge, sample 1ns later, edge follows
    task automatic step(input string name, input vec_t v);
        @(negedge CLK);
        drive(v);
        #1;
        check(name, v.ctl, v.hlt, v.st, v.cnt);
    endtask

    initial begin
        vec_t v;
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_N, 0, 0, 0);
        drive(v);
        @(posedge CLK);

        // reset with noisy inputs, then idle
        tbl.push_back(mk(1, 0, 0, 3, 8, 1, 8, 1, 1, 1, 1, C_N,  0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_N,  0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_A,  0, 0, 0));
        // load-use on rt, then load advances; r0 destination never stalls
        tbl.push_back(mk(0, 1, 0, 3, 8, 1, 8, 0, 0, 0, 0, C_LU, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 3, 8, 0, 8, 0, 0, 0, 0, C_A,  0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_A,  0, 0, 1));
        // dcache load wait, 3 miss cycles then hit
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_N,  0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_N,  0, 1, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_N,  0, 1, 3));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, C_A,  0, 1, 4));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_A,  0, 0, 4));
        // branch during store wait: flush deferred to first RUN cycle after release
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_N,  0, 0, 4));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_N,  0, 1, 5));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, C_A,  0, 1, 6));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_BR, 0, 0, 6));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_A,  0, 0, 6));
        // branch beats load-use and icache miss
        tbl.push_back(mk(0, 0, 0, 5, 9, 1, 5, 0, 0, 1, 0, C_BR, 0, 0, 6));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_A,  0, 0, 6));
        // icache miss alone
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_LU, 0, 0, 6));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_A,  0, 0, 7));
        // halt reaches MEM/WB together with an icache miss
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_H,  0, 0, 7));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // halted: frozen for 20 cycles regardless of inputs
        for (int i = 0; i < 20; i++) begin
            v = mk(0, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                   5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   C_N, 1, 2, 8);
            step($sformatf("halted%0d", i), v);
        end
        step("halt_rst",   mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_N, 1, 2, 8));
        step("post_rst",   mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_A, 0, 0, 0));

        // saturation: 65534 unchecked stall cycles, then watch the top end
        v = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_N, 0, 1, 0);
        for (int i = 0; i < 65534; i++) begin
            @(negedge CLK);
            drive(v);
        end
        v.cnt = 16'd65534;
        step("sat_m1", v);
        v.cnt = 16'd65535;
        step("sat_0", v);
        step("sat_1", v);
        step("sat_2", v);
        step("sat_rel",    mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, C_A, 0, 1, 65535));
        step("sat_idle",   mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_A, 0, 0, 65535));
        // halt outranks a busy dcache
        step("halt_busy",  mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, C_H, 0, 0, 65535));
        step("halt_sat",   mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_N, 1, 2, 65535));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
